// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller.
// Holds the FSM state enum, command opcodes and the default counter width.
package counter_ctrl_pkg;

   localparam int COUNTER_CTRL_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_LIMIT = 2'b01;
   localparam logic [1:0] OP_START = 2'b10;
   localparam logic [1:0] OP_ABORT = 2'b11;

endpackage

// File: rtl/counter_ctrl.sv
// Controller that loads, runs and monitors an external settable counter.
// Define COUNTER_CTRL_AUTORELOAD_EN to restart from DONE straight into LOAD.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = COUNTER_CTRL_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] count_i,
   output logic             set_o,
   output logic [WIDTH-1:0] set_value_o,
   output logic             count_en_o,
   output logic             done_o,
   output logic             busy_o
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             cmd_fire;
   logic             at_limit;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign at_limit = (count_i == limit_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         start_q <= '0;
         limit_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         limit_q <= limit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      limit_d = limit_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (cmd_op)
                  OP_LOAD:  start_d = cmd_data;
                  OP_LIMIT: limit_d = cmd_data;
                  OP_START: state_d = ST_LOAD;
                  default:  state_d = ST_IDLE;
               endcase
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            // ABORT wins over a terminal count in the same cycle.
            if (cmd_fire && (cmd_op == OP_ABORT)) begin
               state_d = ST_IDLE;
            end else if (at_limit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
            state_d = ST_LOAD;
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = 1'b0;
      set_o      = 1'b0;
      count_en_o = 1'b0;
      done_o     = 1'b0;
      busy_o     = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: cmd_ready = 1'b1;
         ST_LOAD: set_o = 1'b1;
         ST_RUN: begin
            cmd_ready  = 1'b1;
            count_en_o = !at_limit;
         end
         ST_DONE: done_o = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   assign set_value_o = start_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench: counter_ctrl driving a bench-side settable counter,
// checked cycle by cycle against a job-timeline model plus directed scenarios.
module tb_counter_ctrl;

   localparam int W = 8;
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_LIMIT = 2'b01;
   localparam logic [1:0] OP_START = 2'b10;
   localparam logic [1:0] OP_ABORT = 2'b11;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_data = '0;
   logic         cmd_ready;
   logic [W-1:0] cnt = '0;
   logic         set_o;
   logic [W-1:0] set_value_o;
   logic         count_en_o;
   logic         done_o;
   logic         busy_o;

   int errors = 0;
   int checks = 0;

   counter_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_ready(cmd_ready), .count_i(cnt),
      .set_o(set_o), .set_value_o(set_value_o), .count_en_o(count_en_o),
      .done_o(done_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Settable counter: set beats enable, increments by one, wraps naturally.
   always @(posedge clk) begin
      if (set_o) cnt <= set_value_o;
      else if (count_en_o) cnt <= cnt + 1'b1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: a job is a timeline indexed by m_k (-1 = idle). Step 0 is the
   // load strobe, steps 1..N+1 are run cycles with N=(limit-start) mod 2^W,
   // and step N+2 is the done pulse.
   int           m_k = -1;
   logic [W-1:0] m_start = '0;
   logic [W-1:0] m_limit = '0;
   logic [W-1:0] m_diff;
   int           m_n;
   logic exp_set, exp_en, exp_done, exp_busy, exp_ready;

   always_comb begin
      m_diff    = m_limit - m_start;
      m_n       = int'(m_diff);
      exp_busy  = (m_k >= 0);
      exp_set   = (m_k == 0);
      exp_en    = (m_k >= 1) && (m_k <= m_n);
      exp_done  = (m_k == m_n + 2);
      exp_ready = !(exp_set || exp_done);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_k     <= -1;
         m_start <= '0;
         m_limit <= '0;
      end else begin
         if (m_k < 0) begin
            if (cmd_valid && exp_ready) begin
               if (cmd_op == OP_LOAD)  m_start <= cmd_data;
               if (cmd_op == OP_LIMIT) m_limit <= cmd_data;
               if (cmd_op == OP_START) m_k <= 0;
            end
         end else if (m_k <= m_n + 1) begin
            if ((m_k >= 1) && cmd_valid && (cmd_op == OP_ABORT)) m_k <= -1;
            else m_k <= m_k + 1;
         end else begin
            m_k <= AUTO ? 0 : -1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
         check("set_o", 32'(set_o), 32'(exp_set));
         check("set_value_o", 32'(set_value_o), 32'(m_start));
         check("count_en_o", 32'(count_en_o), 32'(exp_en));
         check("done_o", 32'(done_o), 32'(exp_done));
         check("busy_o", 32'(busy_o), 32'(exp_busy));
      end
   end

   // Event tallies used by the directed scenarios.
   int cyc = 0, tot_set = 0, tot_en = 0, tot_done = 0;
   int last_set_cyc = 0, last_done_cyc = 0;
   logic [W-1:0] last_set_val = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (set_o) begin
         tot_set      <= tot_set + 1;
         last_set_val <= set_value_o;
         last_set_cyc <= cyc;
      end
      if (count_en_o) tot_en <= tot_en + 1;
      if (done_o) begin
         tot_done      <= tot_done + 1;
         last_done_cyc <= cyc;
      end
   end

   task automatic cmd(input logic [1:0] op, input logic [W-1:0] data);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = OP_ABORT; cmd_data = '0;
      repeat (4) @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input int max_cyc);
      int d0 = tot_done;
      int n  = 0;
      while ((tot_done == d0) && (n < max_cyc)) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (tot_done == d0) check("wait_done_timeout", 32'(0), 32'(1));
   endtask

   task automatic job(input logic [W-1:0] s, input logic [W-1:0] l,
                      input int en_exp, input int lat_exp, input string nm);
      int s0, e0;
      cmd(OP_LOAD, s);
      cmd(OP_LIMIT, l);
      s0 = tot_set; e0 = tot_en;
      cmd(OP_START, 8'd0);
      wait_done(400);
      check({nm, "_set_count"}, 32'(tot_set - s0), 32'(1));
      check({nm, "_set_value"}, 32'(last_set_val), 32'(s));
      check({nm, "_en_cycles"}, 32'(tot_en - e0), 32'(en_exp));
      check({nm, "_done_latency"}, 32'(last_done_cyc - last_set_cyc), 32'(lat_exp));
      check({nm, "_busy_after_done"}, 32'(busy_o), 32'(AUTO));
      go_idle();
   endtask

   initial begin
      int d0, n;
      #1;
      check("reset_busy", 32'(busy_o), 32'(0));
      check("reset_ready", 32'(cmd_ready), 32'(1));
      check("reset_set_value", 32'(set_value_o), 32'(0));
      check("reset_en", 32'(count_en_o), 32'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      job(8'd5, 8'd9, 4, 6, "basic");
      job(8'd250, 8'd3, 9, 11, "wrap");
      job(8'd7, 8'd7, 0, 2, "equal");

      // ABORT presented exactly when the count reaches the limit.
      cmd(OP_LOAD, 8'd5);
      cmd(OP_LIMIT, 8'd8);
      cmd(OP_START, 8'd0);
      d0 = tot_done; n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while ((cnt != 8'd8) && (n < 20));
      check("abort_reached_limit", 32'(cnt), 32'(8));
      cmd_valid = 1'b1; cmd_op = OP_ABORT;
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 32'(tot_done - d0), 32'(0));
      check("abort_idle", 32'(busy_o), 32'(0));

      // Asynchronous reset mid-run at count 20.
      cmd(OP_LOAD, 8'd10);
      cmd(OP_LIMIT, 8'd40);
      cmd(OP_START, 8'd0);
      d0 = tot_done; n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while ((cnt != 8'd20) && (n < 30));
      #2;
      check("rst_pre_en", 32'(count_en_o), 32'(1));
      rst = 1'b1;
      #1;
      check("rst_en_async", 32'(count_en_o), 32'(0));
      check("rst_busy_async", 32'(busy_o), 32'(0));
      check("rst_ready_async", 32'(cmd_ready), 32'(1));
      check("rst_start_cleared", 32'(set_value_o), 32'(0));
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_no_done", 32'(tot_done - d0), 32'(0));
      cmd(OP_START, 8'd0);
      wait_done(50);
      check("rst_reload_value", 32'(last_set_val), 32'(0));
      check("rst_limit_cleared", 32'(last_done_cyc - last_set_cyc), 32'(2));
      go_idle();

`ifdef COUNTER_CTRL_AUTORELOAD_EN
      begin
         int c1, c2, c3;
         cmd(OP_LOAD, 8'd0);
         cmd(OP_LIMIT, 8'd2);
         cmd(OP_START, 8'd0);
         wait_done(50); c1 = last_done_cyc;
         wait_done(50); c2 = last_done_cyc;
         wait_done(50); c3 = last_done_cyc;
         check("auto_period1", 32'(c2 - c1), 32'(5));
         check("auto_period2", 32'(c3 - c2), 32'(5));
         go_idle();
         check("auto_abort_idle", 32'(busy_o), 32'(0));
      end
`endif

      // Random command traffic, checked only by the per-cycle model compare.
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         cmd_valid = ($urandom_range(0, 2) == 0);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_data  = 8'($urandom_range(0, 255));
      end
      #1 cmd_valid = 1'b0;
      go_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
